// File: rtl/operand_writeback_if.sv
// Writeback request channel between the execute stage and operand_writeback.
// The master issues a retiring instruction's operand write; the slave reports ready/done.
interface operand_writeback_if;
   logic        wb_valid;
   logic        wb_ready;
   logic [34:0] wb_desc;
   logic [2:0]  wb_dest_reg;
   logic        wb_byte;
   logic        wb_nowrite;
   logic [15:0] wb_result;
   logic [15:0] wb_pc;
   logic        wb_done;

   modport master (
      output wb_valid, wb_desc, wb_dest_reg, wb_byte, wb_nowrite, wb_result, wb_pc,
      input  wb_ready, wb_done
   );

   modport slave (
      input  wb_valid, wb_desc, wb_dest_reg, wb_byte, wb_nowrite, wb_result, wb_pc,
      output wb_ready, wb_done
   );
endinterface

// File: rtl/operand_writeback.sv
// Retires one instruction: writes its result to a register or big-endian memory,
// then updates the PC and pulses wb_done. All outputs come straight from flops.
//
// state  | meaning
// IDLE   | wb_ready=1, waiting for a request
// REG_WR | one-cycle register-file write
// MEM_HI | high byte to EA, held until mem_ack
// MEM_LO | low byte to EA+1 (word) or EA (byte), held until mem_ack
// PC_UPD | one-cycle PC update and wb_done pulse
module operand_writeback (
   input  logic                      clk,
   input  logic                      reset,
   operand_writeback_if.slave        wb,
   output logic                      reg_we,
   output logic [2:0]                reg_waddr,
   output logic [15:0]               reg_wdata,
   output logic [1:0]                reg_be,
   output logic                      mem_we,
   output logic [15:0]               mem_addr,
   output logic [7:0]                mem_wdata,
   input  logic                      mem_ack,
   output logic                      pc_we,
   output logic [15:0]               pc_next
);

   typedef enum logic [2:0] {IDLE, REG_WR, MEM_HI, MEM_LO, PC_UPD} state_t;

   state_t      state, state_next;
   logic        ready_q, done_q;
   logic        accept;

   logic [15:0] lat_ea, lat_result, lat_pc;
   logic [2:0]  lat_dest;
   logic        lat_byte, lat_pc4;

   logic [15:0] n_ea, n_result, n_pc;
   logic [2:0]  n_dest;
   logic        n_byte, n_pc4;

   logic        reg_we_n, mem_we_n, pc_we_n, done_n, ready_n;
   logic [2:0]  reg_waddr_n;
   logic [15:0] reg_wdata_n, mem_addr_n, pc_next_n;
   logic [1:0]  reg_be_n;
   logic [7:0]  mem_wdata_n;

   // PC-relative flag and the low descriptor half carry nothing for this stage.
   logic        desc_unused;
   assign desc_unused = ^{wb.wb_desc[34], wb.wb_desc[15:0]};

   assign accept      = wb.wb_valid && ready_q;
   assign wb.wb_ready = ready_q;
   assign wb.wb_done  = done_q;

   always_comb begin
      state_next  = state;
      n_ea        = lat_ea;
      n_result    = lat_result;
      n_pc        = lat_pc;
      n_dest      = lat_dest;
      n_byte      = lat_byte;
      n_pc4       = lat_pc4;
      reg_we_n    = 1'b0;
      reg_waddr_n = 3'd0;
      reg_wdata_n = 16'h0000;
      reg_be_n    = 2'b00;
      mem_we_n    = 1'b0;
      mem_addr_n  = 16'h0000;
      mem_wdata_n = 8'h00;
      pc_we_n     = 1'b0;
      pc_next_n   = 16'h0000;
      done_n      = 1'b0;
      ready_n     = 1'b0;

      if (accept) begin
         n_ea     = wb.wb_desc[31:16];
         n_pc4    = wb.wb_desc[33];
         n_result = wb.wb_result;
         n_pc     = wb.wb_pc;
         n_dest   = wb.wb_dest_reg;
         n_byte   = wb.wb_byte;
      end

      case (state)
         IDLE: begin
            if (accept) begin
               if (wb.wb_nowrite)        state_next = PC_UPD;
               else if (!wb.wb_desc[32]) state_next = REG_WR;
               else if (wb.wb_byte)      state_next = MEM_LO;
               else                      state_next = MEM_HI;
            end
         end
         REG_WR:  state_next = PC_UPD;
         MEM_HI:  if (mem_ack) state_next = MEM_LO;
         MEM_LO:  if (mem_ack) state_next = PC_UPD;
         PC_UPD:  state_next = IDLE;
         default: state_next = IDLE;
      endcase

      // Outputs are decoded from the state being entered so they register with it.
      case (state_next)
         IDLE: ready_n = 1'b1;
         REG_WR: begin
            reg_we_n    = 1'b1;
            reg_waddr_n = n_dest;
            reg_wdata_n = n_byte ? {8'h00, n_result[7:0]} : n_result;
            reg_be_n    = n_byte ? 2'b01 : 2'b11;
         end
         MEM_HI: begin
            mem_we_n    = 1'b1;
            mem_addr_n  = n_ea;
            mem_wdata_n = n_result[15:8];
         end
         MEM_LO: begin
            mem_we_n    = 1'b1;
            mem_addr_n  = n_byte ? n_ea : n_ea + 16'd1;
            mem_wdata_n = n_result[7:0];
         end
         PC_UPD: begin
            pc_we_n   = 1'b1;
            done_n    = 1'b1;
            pc_next_n = n_pc + (n_pc4 ? 16'd4 : 16'd2);
         end
         default: ready_n = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
         lat_ea     <= 16'h0000;
         lat_result <= 16'h0000;
         lat_pc     <= 16'h0000;
         lat_dest   <= 3'd0;
         lat_byte   <= 1'b0;
         lat_pc4    <= 1'b0;
         reg_we     <= 1'b0;
         reg_waddr  <= 3'd0;
         reg_wdata  <= 16'h0000;
         reg_be     <= 2'b00;
         mem_we     <= 1'b0;
         mem_addr   <= 16'h0000;
         mem_wdata  <= 8'h00;
         pc_we      <= 1'b0;
         pc_next    <= 16'h0000;
      end else begin
         state      <= state_next;
         ready_q    <= ready_n;
         done_q     <= done_n;
         lat_ea     <= n_ea;
         lat_result <= n_result;
         lat_pc     <= n_pc;
         lat_dest   <= n_dest;
         lat_byte   <= n_byte;
         lat_pc4    <= n_pc4;
         reg_we     <= reg_we_n;
         reg_waddr  <= reg_waddr_n;
         reg_wdata  <= reg_wdata_n;
         reg_be     <= reg_be_n;
         mem_we     <= mem_we_n;
         mem_addr   <= mem_addr_n;
         mem_wdata  <= mem_wdata_n;
         pc_we      <= pc_we_n;
         pc_next    <= pc_next_n;
      end
   end

endmodule

// File: tb/tb_operand_writeback.sv
// Directed bench for operand_writeback: stimulus pushes hand-computed writes into a
// queue, a negedge monitor compares every register/memory/PC write against it.
module tb_operand_writeback;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        reg_we, mem_we, pc_we, mem_ack;
   logic [2:0]  reg_waddr;
   logic [15:0] reg_wdata, mem_addr, pc_next;
   logic [1:0]  reg_be;
   logic [7:0]  mem_wdata;

   int checks = 0;
   int errors = 0;
   int stall_cfg = 0;
   int stall_left = 0;
   logic force_nack = 1'b0;
   logic ack_idle = 1'b1;

   typedef struct {
      int          kind;   // 0 reg write, 1 memory byte, 2 PC update
      logic [15:0] addr;
      logic [15:0] data;
      logic [1:0]  be;
   } ev_t;
   ev_t exp_q[$];

   always #5 clk = ~clk;

   operand_writeback_if wb();

   operand_writeback dut (
      .clk(clk), .reset(reset), .wb(wb),
      .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_be(reg_be),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .pc_we(pc_we), .pc_next(pc_next)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic exp_reg(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
      ev_t e;
      e.kind = 0; e.addr = {13'd0, a}; e.data = d; e.be = be;
      exp_q.push_back(e);
   endtask

   task automatic exp_mem(input logic [15:0] a, input logic [7:0] d);
      ev_t e;
      e.kind = 1; e.addr = a; e.data = {8'h00, d}; e.be = 2'b00;
      exp_q.push_back(e);
   endtask

   task automatic exp_pc(input logic [15:0] v);
      ev_t e;
      e.kind = 2; e.addr = v; e.data = 16'h0000; e.be = 2'b00;
      exp_q.push_back(e);
   endtask

   task automatic mon_ev(input string name, input int kind, input logic [15:0] addr,
                         input logic [15:0] data, input logic [1:0] be, input logic pop);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: unexpected write addr=%h data=%h be=%b, none required", name, addr, data, be);
      end else begin
         e = exp_q[0];
         if (e.kind != kind || e.addr !== addr || e.data !== data || e.be !== be) begin
            errors++;
            $display("FAIL %s: got kind=%0d addr=%h data=%h be=%b, required kind=%0d addr=%h data=%h be=%b",
                     name, kind, addr, data, be, e.kind, e.addr, e.data, e.be);
         end
         if (pop) void'(exp_q.pop_front());
      end
   endtask

   // Memory responder followed by the scoreboard monitor, in one block so the
   // monitor sees the same mem_ack the DUT samples at the next rising edge.
   always @(negedge clk) begin
      if (mem_we) begin
         if (force_nack) mem_ack = 1'b0;
         else if (stall_left > 0) begin mem_ack = 1'b0; stall_left--; end
         else begin mem_ack = 1'b1; stall_left = stall_cfg; end
      end else begin
         mem_ack = ack_idle;
         stall_left = stall_cfg;
      end

      if (!reset) begin
         if (reg_we) mon_ev("reg_write", 0, {13'd0, reg_waddr}, reg_wdata, reg_be, 1'b1);
         if (mem_we) mon_ev("mem_write", 1, mem_addr, {8'h00, mem_wdata}, 2'b00, mem_ack);
         if (pc_we) begin
            mon_ev("pc_update", 2, pc_next, 16'h0000, 2'b00, 1'b1);
            check("wb_done_with_pc", wb.wb_done, 1);
         end
         if (wb.wb_done && !pc_we) begin
            checks++;
            errors++;
            $display("FAIL wb_done_alone: got wb_done=1 with pc_we=0, required wb_done=0");
         end
      end
   end

   function automatic logic [34:0] mk_desc(input logic pcrel, input logic pc4, input logic mem,
                                           input logic [15:0] ea);
      return {pcrel, pc4, mem, ea, 16'h5A5A};
   endfunction

   task automatic sync();
      @(posedge clk); #1;
   endtask

   task automatic drive(input logic [34:0] desc, input logic [2:0] dest, input logic bm,
                        input logic nowr, input logic [15:0] res, input logic [15:0] pc);
      wb.wb_desc = desc; wb.wb_dest_reg = dest; wb.wb_byte = bm;
      wb.wb_nowrite = nowr; wb.wb_result = res; wb.wb_pc = pc;
   endtask

   task automatic issue(input string name);
      int n = 0;
      wb.wb_valid = 1'b1;
      while (!wb.wb_ready && n < 50) begin sync(); n++; end
      check({name, "_ready"}, wb.wb_ready, 1);
      sync();
   endtask

   task automatic wait_done(input string name, input int exp_lat);
      int lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!wb.wb_done && lat < 100);
      check(name, lat, exp_lat);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, required run to complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      int n;
      mem_ack = 1'b0;
      // A pending nowrite request during reset must not be taken.
      drive(mk_desc(0, 1, 0, 16'h0000), 3'd0, 1'b0, 1'b1, 16'h0000, 16'h0100);
      wb.wb_valid = 1'b1;
      repeat (3) sync();
      check("rst_ready", wb.wb_ready, 1);
      check("rst_reg_we", reg_we, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_pc_we", pc_we, 0);
      check("rst_done", wb.wb_done, 0);
      check("rst_reg_waddr", reg_waddr, 0);
      check("rst_reg_wdata", reg_wdata, 0);
      check("rst_reg_be", reg_be, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_pc_next", pc_next, 0);
      reset = 1'b0;
      wb.wb_valid = 1'b0;
      repeat (2) sync();

      // Register word, R3.
      drive(mk_desc(0, 0, 0, 16'h0000), 3'd3, 1'b0, 1'b0, 16'o123456, 16'o001000);
      exp_reg(3'd3, 16'o123456, 2'b11);
      exp_pc(16'o001002);
      issue("reg_word");
      wb.wb_valid = 1'b0;
      wait_done("reg_word_latency", 2);
      sync();

      // Register byte, PC-relative flag set (no effect), PC+4.
      drive(mk_desc(1, 1, 0, 16'hBEEF), 3'd5, 1'b1, 1'b0, 16'h12AB, 16'h1000);
      exp_reg(3'd5, 16'h00AB, 2'b01);
      exp_pc(16'h1004);
      issue("reg_byte");
      wb.wb_valid = 1'b0;
      wait_done("reg_byte_latency", 2);
      sync();

      // Memory word, two stall cycles per byte.
      stall_cfg = 2;
      drive(mk_desc(0, 1, 1, 16'o002000), 3'd0, 1'b0, 1'b0, 16'hA55A, 16'h0100);
      exp_mem(16'o002000, 8'hA5);
      exp_mem(16'o002001, 8'h5A);
      exp_pc(16'h0104);
      issue("mem_word_stall");
      wb.wb_valid = 1'b0;
      wait_done("mem_word_stall_latency", 7);
      sync();

      // Byte at FFFF: single write, no wrap.
      stall_cfg = 0;
      drive(mk_desc(0, 0, 1, 16'hFFFF), 3'd0, 1'b1, 1'b0, 16'h12AB, 16'h0200);
      exp_mem(16'hFFFF, 8'hAB);
      exp_pc(16'h0202);
      issue("mem_byte_ffff");
      wb.wb_valid = 1'b0;
      wait_done("mem_byte_ffff_latency", 2);
      sync();

      // Word at FFFF: low byte wraps to 0000.
      stall_cfg = 1;
      drive(mk_desc(0, 1, 1, 16'hFFFF), 3'd0, 1'b0, 1'b0, 16'h12AB, 16'h0300);
      exp_mem(16'hFFFF, 8'h12);
      exp_mem(16'h0000, 8'hAB);
      exp_pc(16'h0304);
      issue("mem_word_ffff");
      wb.wb_valid = 1'b0;
      wait_done("mem_word_ffff_latency", 5);
      sync();
      stall_cfg = 0;

      // Nowrite with memory destination bit set: PC only, wraps to 0002.
      drive(mk_desc(0, 1, 1, 16'h4000), 3'd6, 1'b0, 1'b1, 16'hFFFF, 16'hFFFE);
      exp_pc(16'h0002);
      issue("nowrite");
      wb.wb_valid = 1'b0;
      wait_done("nowrite_latency", 1);
      sync();

      // Reset while MEM_HI is stalled: the operation is dropped.
      force_nack = 1'b1;
      drive(mk_desc(0, 0, 1, 16'h1234), 3'd0, 1'b0, 1'b0, 16'hBEEF, 16'h0400);
      exp_mem(16'h1234, 8'hBE);
      issue("abort");
      wb.wb_valid = 1'b0;
      n = 0;
      while (!mem_we && n < 20) begin @(negedge clk); n++; end
      check("abort_in_mem_hi", mem_we, 1);
      repeat (2) sync();
      reset = 1'b1;
      sync();
      exp_q.delete();
      check("abort_ready", wb.wb_ready, 1);
      check("abort_mem_we", mem_we, 0);
      check("abort_pc_we", pc_we, 0);
      check("abort_mem_addr", mem_addr, 0);
      reset = 1'b0;
      force_nack = 1'b0;
      repeat (4) sync();

      // Normal request after the abort.
      drive(mk_desc(0, 0, 0, 16'h0000), 3'd0, 1'b0, 1'b0, 16'h0001, 16'h0010);
      exp_reg(3'd0, 16'h0001, 2'b11);
      exp_pc(16'h0012);
      issue("after_abort");
      wb.wb_valid = 1'b0;
      wait_done("after_abort_latency", 2);
      sync();

      // Back-to-back with wb_valid held; second request's inputs appear mid-operation.
      drive(mk_desc(0, 0, 0, 16'h0000), 3'd7, 1'b0, 1'b0, 16'h5555, 16'h2000);
      exp_reg(3'd7, 16'h5555, 2'b11);
      exp_pc(16'h2002);
      issue("b2b_first");
      drive(mk_desc(0, 1, 1, 16'h0080), 3'd2, 1'b1, 1'b0, 16'h3377, 16'h3000);
      exp_mem(16'h0080, 8'h77);
      exp_pc(16'h3004);
      wait_done("b2b_first_latency", 2);
      check("b2b_ready_at_done", wb.wb_ready, 0);
      @(negedge clk);
      check("b2b_ready_after_done", wb.wb_ready, 1);
      sync();
      wb.wb_valid = 1'b0;
      wait_done("b2b_second_latency", 2);
      repeat (3) sync();

      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/operand_writeback.md
OPERAND_WRITEBACK -- requirements
Module: operand_writeback

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 wb_valid  input  1  writeback request; accepted on a rising edge where wb_valid=1 and wb_ready=1.
REQ-004 wb_ready  output  1  high only in IDLE.
REQ-005 wb_desc  input  35  operand descriptor: [34] PC-relative, [33] PC+4 (else PC+2), [32] memory destination (else register), [31:16] effective address, [15:0] ignored.
REQ-006 wb_dest_reg  input  3  destination register number; used only when wb_desc[32]=0.
REQ-007 wb_byte  input  1  1 = byte access, 0 = word access.
REQ-008 wb_nowrite  input  1  1 = no operand write (CMP/BIT/TST class); PC update only.
REQ-009 wb_result  input  16  ALU result to store.
REQ-010 wb_pc  input  16  PC of the instruction being retired.
REQ-011 reg_we / reg_waddr / reg_wdata / reg_be  output  1/3/16/2  register-file write strobe, register number, data, byte enables ([1] high byte, [0] low byte).
REQ-012 mem_we / mem_addr / mem_wdata  output  1/16/8  byte-wide memory write request, address, data.
REQ-013 mem_ack  input  1  memory accepted the current byte write.
REQ-014 pc_we / pc_next  output  1/16  program-counter update strobe and value.
REQ-015 wb_done  output  1  one-cycle pulse: writeback complete.

Function
REQ-016 FSM states: IDLE, REG_WR, MEM_HI, MEM_LO, PC_UPD.
REQ-017 On acceptance, latch all wb_* inputs. Later input changes have no effect until the next acceptance.
REQ-018 Transitions out of IDLE on acceptance:
- wb_nowrite=1 -> PC_UPD.
- else wb_desc[32]=0 -> REG_WR.
- else wb_byte=1 -> MEM_LO.
- else -> MEM_HI.
REQ-019 REG_WR, one cycle:
- reg_we=1, reg_waddr = latched wb_dest_reg.
- Word: reg_wdata = result, reg_be=2'b11.
- Byte: reg_wdata = {8'h00, result[7:0]}, reg_be=2'b01.
- Next state PC_UPD.
REQ-020 MEM_HI:
- mem_we=1, mem_addr=EA, mem_wdata=result[15:8].
- Held until mem_ack=1 is sampled; then MEM_LO.
REQ-021 MEM_LO:
- mem_we=1, mem_wdata=result[7:0].
- mem_addr = EA+1 (mod 2^16) for word access; EA for byte access.
- Held until mem_ack=1 is sampled; then PC_UPD.
REQ-022 Big-endian byte order: high byte at EA, low byte at EA+1. EA=16'hFFFF wraps the low-byte address to 16'h0000.
REQ-023 PC_UPD, one cycle:
- pc_we=1, wb_done=1.
- pc_next = wb_pc + 4 if latched wb_desc[33]=1, else wb_pc + 2, computed modulo 2^16.
- Next state IDLE.
REQ-024 Outside their states, reg_we, mem_we, pc_we and wb_done SHALL be 0.
REQ-025 Outputs are registered. Zero-wait latency from the acceptance edge to wb_done:
- register path: 2 cycles.
- word memory: 3 cycles.
- byte memory or nowrite: 2 cycles for byte memory, 1 cycle for nowrite.
REQ-026 Each mem_ack low cycle adds one cycle of latency. mem_addr and mem_wdata SHALL stay stable while mem_we=1.
REQ-027 mem_ack while mem_we=0 is ignored.
REQ-028 wb_valid while wb_ready=0 is ignored and not queued.
REQ-029 wb_desc[34] does not alter behaviour. The PC-relative target address is already resolved in wb_desc[31:16].

Reset
REQ-030 While reset=1 at a clock edge:
- next state IDLE.
- wb_ready=1.
- reg_we, mem_we, pc_we, wb_done = 0.
- reg_waddr, reg_wdata, reg_be, mem_addr, mem_wdata, pc_next = 0.
- latched request cleared.
REQ-031 Reset in any non-IDLE state aborts the operation. No further byte write, register write or PC update for it. A half-written word is left as-is.
REQ-032 Reset has priority over wb_valid on the same edge.

Verification
REQ-033 Register word: mode-0 dest R3, result 16'o123456, pc 16'o001000, desc[33]=0 -> reg_we one cycle (R3, 16'o123456, be=11); next cycle pc_we with pc_next 16'o001002 and wb_done.
REQ-034 Memory word with stalls: EA 16'o002000, result 16'hA55A, mem_ack low 2 cycles on each byte -> writes A5@2000, then 5A@2001; pc_next = pc+4 when desc[33]=1; wb_done once.
REQ-035 Byte memory at wrap: EA 16'hFFFF, result 16'h12AB, byte=1 -> single write AB@FFFF. Word at FFFF -> 12@FFFF, then AB@0000.
REQ-036 Nowrite: wb_nowrite=1, pc 16'hFFFE, desc[33]=1 -> no reg_we or mem_we; pc_next 16'h0002; wb_done 1 cycle after acceptance.
REQ-037 Reset mid-op: reset asserted during MEM_HI with mem_ack=0 -> no MEM_LO write, no pc_we, wb_ready=1 the next cycle. A new request then completes normally.
REQ-038 Back-to-back: wb_valid held high across two requests -> second accepted only in the cycle after wb_done; inputs changed mid-operation do not alter the first request's writes.
